// File: rtl/pc_ctrl_if.sv
// Hazard inputs and PC control outputs of the stage1 PC sequencing controller.
// master drives the hazards and consumes the controls; slave is pc_ctrl itself.
interface pc_ctrl_if;
  logic icache_stall;
  logic dcache_stall;
  logic s2_valid;
  logic br_taken;
  logic jump;
  logic stall;
  logic pc_sel;
  logic s1_flush;
  logic busy;

  modport master (
    output icache_stall, dcache_stall, s2_valid, br_taken, jump,
    input  stall, pc_sel, s1_flush, busy
  );

  modport slave (
    input  icache_stall, dcache_stall, s2_valid, br_taken, jump,
    output stall, pc_sel, s1_flush, busy
  );
endinterface

// File: rtl/pc_ctrl.sv
// Stage1 PC sequencing controller: boot hold, cache-miss stalls, stage2 redirects.
// Optional performance counters are enabled with `define PC_CTRL_PERF_EN.
module pc_ctrl #(
  parameter int unsigned RESET_HOLD_CYCLES = 2,
  parameter int unsigned REDIRECT_BUBBLES  = 1
) (
  input  logic        clk,
  input  logic        reset,
  pc_ctrl_if.slave    bus
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // A zero boot hold skips BOOT entirely, so its terminal count is never used then.
  localparam int     BOOT_LAST_I  = (RESET_HOLD_CYCLES == 0) ? 0 : int'(RESET_HOLD_CYCLES) - 1;
  localparam int     FLUSH_LAST_I = int'(REDIRECT_BUBBLES) - 1;
  localparam logic [3:0] BOOT_LAST  = 4'(BOOT_LAST_I);
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_LAST_I);
  localparam state_e RESET_STATE  = (RESET_HOLD_CYCLES == 0) ? ST_RUN : ST_BOOT;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic cache_stall;
  logic redirect_req;
  logic accept;

  logic stall_o;
  logic pc_sel_o;
  logic s1_flush_o;
  logic busy_o;

  assign cache_stall  = bus.icache_stall | bus.dcache_stall;
  assign redirect_req = bus.s2_valid & (bus.br_taken | bus.jump);
  assign accept       = (state_q == ST_RUN) & redirect_req & ~cache_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_BOOT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        // A redirect seen under a cache stall simply waits: stage2 is frozen and re-presents it.
        if (accept) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (!cache_stall) begin
          if (cnt_q == FLUSH_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_o    = 1'b1;
    pc_sel_o   = 1'b0;
    s1_flush_o = 1'b1;
    busy_o     = 1'b1;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          stall_o    = cache_stall;
          pc_sel_o   = accept;
          s1_flush_o = accept;
          busy_o     = 1'b0;
        end
        ST_FLUSH: begin
          stall_o    = cache_stall;
        end
        default: begin
          stall_o    = 1'b1;
        end
      endcase
    end
  end

  assign bus.stall    = stall_o;
  assign bus.pc_sel   = pc_sel_o;
  assign bus.s1_flush = s1_flush_o;
  assign bus.busy     = busy_o;

`ifdef PC_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] redirect_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      if ((state_q != ST_BOOT) && cache_stall) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (accept) begin
        redirect_count_q <= redirect_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: two instances (hold 2 / 1 bubble, hold 0 / 2 bubbles) on shared stimulus.
// Directed scenarios use fixed expectations; a random phase compares against a cycle-count model.
module tb_pc_ctrl;
  localparam int HOLD_A = 2;
  localparam int BUB_A  = 1;
  localparam int HOLD_B = 0;
  localparam int BUB_B  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic icache_stall = 1'b0;
  logic dcache_stall = 1'b0;
  logic s2_valid = 1'b0;
  logic br_taken = 1'b0;
  logic jump = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pc_ctrl_if bus_a ();
  pc_ctrl_if bus_b ();

  assign bus_a.icache_stall = icache_stall;
  assign bus_a.dcache_stall = dcache_stall;
  assign bus_a.s2_valid     = s2_valid;
  assign bus_a.br_taken     = br_taken;
  assign bus_a.jump         = jump;
  assign bus_b.icache_stall = icache_stall;
  assign bus_b.dcache_stall = dcache_stall;
  assign bus_b.s2_valid     = s2_valid;
  assign bus_b.br_taken     = br_taken;
  assign bus_b.jump         = jump;

`ifdef PC_CTRL_PERF_EN
  logic [31:0] stall_cycles_a, redirect_count_a, stall_cycles_b, redirect_count_b;
`endif

  pc_ctrl #(.RESET_HOLD_CYCLES(HOLD_A), .REDIRECT_BUBBLES(BUB_A)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
`ifdef PC_CTRL_PERF_EN
    ,
    .stall_cycles   (stall_cycles_a),
    .redirect_count (redirect_count_a)
`endif
  );

  pc_ctrl #(.RESET_HOLD_CYCLES(HOLD_B), .REDIRECT_BUBBLES(BUB_B)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
`ifdef PC_CTRL_PERF_EN
    ,
    .stall_cycles   (stall_cycles_b),
    .redirect_count (redirect_count_b)
`endif
  );

  // Output bundles are {stall, pc_sel, s1_flush, busy}.
  logic [3:0] out_a, out_b;
  assign out_a = {bus_a.stall, bus_a.pc_sel, bus_a.s1_flush, bus_a.busy};
  assign out_b = {bus_b.stall, bus_b.pc_sel, bus_b.s1_flush, bus_b.busy};

  logic cache_stall, redirect_req;
  assign cache_stall  = icache_stall | dcache_stall;
  assign redirect_req = s2_valid & (br_taken | jump);

  // Model state: cycles of boot hold left, unstalled flush bubbles left, and counters.
  int          boot_left [2];
  int          flush_left[2];
  logic [31:0] m_stall   [2];
  logic [31:0] m_redir   [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        boot_left[d]  <= (d == 0) ? HOLD_A : HOLD_B;
        flush_left[d] <= 0;
        m_stall[d]    <= '0;
        m_redir[d]    <= '0;
      end else if (boot_left[d] > 0) begin
        boot_left[d] <= boot_left[d] - 1;
      end else begin
        if (cache_stall) m_stall[d] <= m_stall[d] + 32'd1;
        if (flush_left[d] > 0) begin
          if (!cache_stall) flush_left[d] <= flush_left[d] - 1;
        end else if (redirect_req && !cache_stall) begin
          flush_left[d] <= (d == 0) ? BUB_A : BUB_B;
          m_redir[d]    <= m_redir[d] + 32'd1;
        end
      end
    end
  end

  function automatic logic [3:0] model_out(int d);
    if (reset || boot_left[d] > 0) return 4'b1011;
    if (flush_left[d] > 0) return {cache_stall, 3'b011};
    return {cache_stall, redirect_req & ~cache_stall, redirect_req & ~cache_stall, 1'b0};
  endfunction

  task automatic drive_idle();
    icache_stall = 1'b0;
    dcache_stall = 1'b0;
    s2_valid     = 1'b0;
    br_taken     = 1'b0;
    jump         = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      icache_stall = 1'($urandom_range(0, 1));
      s2_valid = 1'b1;
      jump = 1'($urandom_range(0, 1));
      @(negedge clk);
      compared += 2;
      if (out_a !== 4'b1011) begin
        mismatched++;
        $display("FAIL reset dut_a cyc%0d: stall/pc_sel/s1_flush/busy got %b want 1011", k, out_a);
      end
      if (out_b !== 4'b1011) begin
        mismatched++;
        $display("FAIL reset dut_b cyc%0d: stall/pc_sel/s1_flush/busy got %b want 1011", k, out_b);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_boot_hold();
    logic [3:0] exp_a[4] = '{4'b1011, 4'b1011, 4'b0000, 4'b0000};
    logic [3:0] exp_b[4] = '{4'b0110, 4'b0011, 4'b0011, 4'b0000};
    reset = 1'b0;
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      s2_valid = (k < 2);
      jump = (k < 2);
      @(negedge clk);
      compared += 2;
      if (out_a !== exp_a[k]) begin
        mismatched++;
        $display("FAIL boot_hold dut_a cyc%0d: got %b want %b", k, out_a, exp_a[k]);
      end
      if (out_b !== exp_b[k]) begin
        mismatched++;
        $display("FAIL boot_hold dut_b cyc%0d: got %b want %b", k, out_b, exp_b[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_plain_stall();
    logic [3:0] want;
    drive_idle();
    for (int k = 0; k < 5; k++) begin
      icache_stall = (k < 4);
      br_taken = 1'($urandom_range(0, 1));
      want = (k < 4) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      compared += 2;
      if (out_a !== want) begin
        mismatched++;
        $display("FAIL plain_stall dut_a cyc%0d: got %b want %b", k, out_a, want);
      end
      if (out_b !== want) begin
        mismatched++;
        $display("FAIL plain_stall dut_b cyc%0d: got %b want %b", k, out_b, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    logic [3:0] exp_a[4] = '{4'b0110, 4'b0011, 4'b0000, 4'b0000};
    logic [3:0] exp_b[4] = '{4'b0110, 4'b0011, 4'b0011, 4'b0000};
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      s2_valid = (k < 2);
      br_taken = (k < 2);
      @(negedge clk);
      compared += 2;
      if (out_a !== exp_a[k]) begin
        mismatched++;
        $display("FAIL redirect dut_a cyc%0d: got %b want %b", k, out_a, exp_a[k]);
      end
      if (out_b !== exp_b[k]) begin
        mismatched++;
        $display("FAIL redirect dut_b cyc%0d: got %b want %b", k, out_b, exp_b[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_deferred_redirect();
    logic [3:0] exp_a[7] = '{4'b1000, 4'b1000, 4'b1000, 4'b0110, 4'b0011, 4'b0000, 4'b0000};
    logic [3:0] exp_b[7] = '{4'b1000, 4'b1000, 4'b1000, 4'b0110, 4'b0011, 4'b0011, 4'b0000};
    drive_idle();
    for (int k = 0; k < 7; k++) begin
      dcache_stall = (k < 3);
      s2_valid = (k < 4);
      jump = (k < 4);
      @(negedge clk);
      compared += 2;
      if (out_a !== exp_a[k]) begin
        mismatched++;
        $display("FAIL deferred dut_a cyc%0d: got %b want %b", k, out_a, exp_a[k]);
      end
      if (out_b !== exp_b[k]) begin
        mismatched++;
        $display("FAIL deferred dut_b cyc%0d: got %b want %b", k, out_b, exp_b[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_during_flush();
    logic [3:0] exp_a[6] = '{4'b0110, 4'b1011, 4'b1011, 4'b0011, 4'b0000, 4'b0000};
    logic [3:0] exp_b[6] = '{4'b0110, 4'b1011, 4'b1011, 4'b0011, 4'b0011, 4'b0000};
    drive_idle();
    for (int k = 0; k < 6; k++) begin
      s2_valid = (k == 0);
      br_taken = (k == 0);
      icache_stall = (k == 1) || (k == 2);
      @(negedge clk);
      compared += 2;
      if (out_a !== exp_a[k]) begin
        mismatched++;
        $display("FAIL flush_stall dut_a cyc%0d: got %b want %b", k, out_a, exp_a[k]);
      end
      if (out_b !== exp_b[k]) begin
        mismatched++;
        $display("FAIL flush_stall dut_b cyc%0d: got %b want %b", k, out_b, exp_b[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [3:0] exp_a[5] = '{4'b0110, 4'b1011, 4'b1011, 4'b1011, 4'b0000};
    logic [3:0] exp_b[5] = '{4'b0110, 4'b1011, 4'b0000, 4'b0000, 4'b0000};
    drive_idle();
    for (int k = 0; k < 5; k++) begin
      s2_valid = (k == 0);
      jump = (k == 0);
      reset = (k == 1);
      @(negedge clk);
      compared += 2;
      if (out_a !== exp_a[k]) begin
        mismatched++;
        $display("FAIL reset_flush dut_a cyc%0d: got %b want %b", k, out_a, exp_a[k]);
      end
      if (out_b !== exp_b[k]) begin
        mismatched++;
        $display("FAIL reset_flush dut_b cyc%0d: got %b want %b", k, out_b, exp_b[k]);
      end
`ifdef PC_CTRL_PERF_EN
      if (k == 2) begin
        compared += 4;
        if (stall_cycles_a !== 32'd0) begin
          mismatched++;
          $display("FAIL reset_flush stall_cycles_a: got %0d want 0", stall_cycles_a);
        end
        if (redirect_count_a !== 32'd0) begin
          mismatched++;
          $display("FAIL reset_flush redirect_count_a: got %0d want 0", redirect_count_a);
        end
        if (stall_cycles_b !== 32'd0) begin
          mismatched++;
          $display("FAIL reset_flush stall_cycles_b: got %0d want 0", stall_cycles_b);
        end
        if (redirect_count_b !== 32'd0) begin
          mismatched++;
          $display("FAIL reset_flush redirect_count_b: got %0d want 0", redirect_count_b);
        end
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [3:0] want_a, want_b;
    for (int k = 0; k < 3000; k++) begin
      reset        = ($urandom_range(0, 99) == 0);
      icache_stall = ($urandom_range(0, 9) < 2);
      dcache_stall = ($urandom_range(0, 9) < 2);
      s2_valid     = 1'($urandom_range(0, 1));
      br_taken     = ($urandom_range(0, 3) == 0);
      jump         = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      want_a = model_out(0);
      want_b = model_out(1);
      compared += 2;
      if (out_a !== want_a) begin
        mismatched++;
        $display("FAIL random dut_a cyc%0d: got %b want %b", k, out_a, want_a);
      end
      if (out_b !== want_b) begin
        mismatched++;
        $display("FAIL random dut_b cyc%0d: got %b want %b", k, out_b, want_b);
      end
`ifdef PC_CTRL_PERF_EN
      compared += 4;
      if (stall_cycles_a !== m_stall[0]) begin
        mismatched++;
        $display("FAIL random stall_cycles_a cyc%0d: got %0d want %0d", k, stall_cycles_a, m_stall[0]);
      end
      if (redirect_count_a !== m_redir[0]) begin
        mismatched++;
        $display("FAIL random redirect_count_a cyc%0d: got %0d want %0d", k, redirect_count_a, m_redir[0]);
      end
      if (stall_cycles_b !== m_stall[1]) begin
        mismatched++;
        $display("FAIL random stall_cycles_b cyc%0d: got %0d want %0d", k, stall_cycles_b, m_stall[1]);
      end
      if (redirect_count_b !== m_redir[1]) begin
        mismatched++;
        $display("FAIL random redirect_count_b cyc%0d: got %0d want %0d", k, redirect_count_b, m_redir[1]);
      end
`endif
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot_hold();
    test_plain_stall();
    test_redirect();
    test_deferred_redirect();
    test_stall_during_flush();
    test_reset_mid_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
